// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam logic [WIDTH_DEF-1:0] DIVZERO_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide,
// sharing a single adder. Multiply keeps {partial_hi, multiplier}; divide keeps {rem, quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  op_e                 op_i,
    input  logic [2*WIDTH-1:0]  acc_i,
    input  logic [WIDTH-1:0]    operand_i,
    output logic [2*WIDTH-1:0]  acc_o
);

    logic             is_div;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH+1:0] add_a;
    logic [WIDTH+1:0] add_b;
    logic [WIDTH+1:0] sum;
    logic             cin;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        is_div  = op_i[1];
        rem_ext = acc_i[2*WIDTH-1:WIDTH-1];
        if (is_div) begin
            add_a = {1'b0, rem_ext};
            add_b = ~{2'b00, operand_i};
            cin   = 1'b1;
        end else begin
            add_a = {2'b00, acc_i[2*WIDTH-1:WIDTH]};
            add_b = acc_i[0] ? {2'b00, operand_i} : '0;
            cin   = 1'b0;
        end
        sum = add_a + add_b + {{(WIDTH+1){1'b0}}, cin};

        // Divide: a non-negative trial difference means the divisor fits this step.
        if (is_div) begin
            if (!sum[WIDTH+1]) begin
                acc_o = {sum[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_ext[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum[WIDTH:0], acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO pair: IDLE -> 32 x CALC -> FIX.
// Raises stall_o on any HI/LO access or new issue while an operation is in flight.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             rd_hilo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               quot_neg_q, quot_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               divzero_q, divzero_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (acc_step)
    );

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign signed_op = ~op_i[0];
    assign mag_a     = (signed_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign mag_b     = (signed_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    assign prod_fix  = (op_q == OP_MULT && quot_neg_q) ? -acc_q : acc_q;
    assign quot_fix  = (op_q == OP_DIV && quot_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = (op_q == OP_DIV && rem_neg_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                                     : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        divzero_d  = divzero_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d       = op_e'(op_i);
                    acc_d      = {{WIDTH{1'b0}}, op_i[1] ? mag_a : mag_b};
                    opnd_d     = op_i[1] ? mag_b : mag_a;
                    quot_neg_d = src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1];
                    rem_neg_d  = src_a_i[WIDTH-1];
                    divzero_d  = op_i[1] && (src_b_i == '0);
                    cnt_d      = '0;
                    state_d    = ST_CALC;
                end else begin
                    if (mthi_i) hi_d = src_a_i;
                    if (mtlo_i) lo_d = src_a_i;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '1) state_d = ST_FIX;
            end
            ST_FIX: begin
                // A zero divisor leaves the remainder equal to the dividend, so HI needs no special case.
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = divzero_q ? DIVZERO_LO : quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            divzero_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            divzero_q  <= divzero_d;
            done_q     <= done_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign stall_o = busy_o & (start_i | mthi_i | mtlo_i | rd_hilo_i);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases, hazards, reset and random ops
// against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [1:0] MULT  = 2'd0;
    localparam logic [1:0] MULTU = 2'd1;
    localparam logic [1:0] DIV   = 2'd2;
    localparam logic [1:0] DIVU  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic        rd_hilo_i = 1'b0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o, stall_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .mthi_i    (mthi_i),
        .mtlo_i    (mtlo_i),
        .rd_hilo_i (rd_hilo_i),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        model = '0;
        case (op)
            MULT:  model = sa * sb;
            MULTU: model = ua * ub;
            DIV: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %h_%h expected no result", hi_o, lo_o);
            end else begin
                check("result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mthi);
        @(negedge clk);
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        start_i = 1'b1;
        mthi_i  = with_mthi;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mthi_i  = 1'b0;
        src_a_i = $urandom;
        src_b_i = $urandom;
        op_i    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (1) begin
            @(negedge clk);
            edges++;
            if (busy_o) busy_cycles++;
            if (done_o) break;
            if (edges >= 100) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no done after %0d cycles expected 34", edges);
                break;
            end
        end
    endtask

    task automatic run_directed(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp_hilo);
        int e, bc;
        issue(op, a, b, 1'b0);
        wait_done(e, bc);
        check({name, "_latency"}, e, 34);
        check({name, "_busy"}, bc, 33);
        check({name, "_hilo"}, {hi_o, lo_o}, exp_hilo);
    endtask

    initial begin
        int          e, bc;
        logic [31:0] a, b;
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0002;

        repeat (3) @(negedge clk);
        check("reset_hilo", {hi_o, lo_o}, 64'h0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_stall", stall_o, 0);
        rst = 1'b1;

        run_directed("mult_neg", MULT, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
        rd_hilo_i = 1'b1;
        #1 check("stall_done_cycle", stall_o, 0);
        rd_hilo_i = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done_o, 0);

        run_directed("multu", MULTU, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE);
        run_directed("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_directed("div_neg", DIV, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_directed("divu", DIVU, 32'hFFFF_FFF9, 32'h2, 64'h0000_0001_7FFF_FFFC);
        run_directed("div_zero", DIV, 32'h0000_1234, 32'h0, 64'h0000_1234_FFFF_FFFF);

        // Hazards while busy: stall, ignored second start, HI/LO untouched until done.
        issue(DIV, 32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        start_i   = 1'b1;
        rd_hilo_i = 1'b1;
        op_i      = MULTU;
        src_a_i   = $urandom;
        #1 check("stall_busy_start", stall_o, 1);
        check("hilo_held_busy", {hi_o, lo_o}, 64'h0000_1234_FFFF_FFFF);
        @(negedge clk);
        start_i   = 1'b0;
        rd_hilo_i = 1'b0;
        #1 check("no_stall_busy_idle_bus", stall_o, 0);
        mthi_i  = 1'b1;
        src_a_i = 32'hDEAD_BEEF;
        #1 check("stall_busy_mthi", stall_o, 1);
        @(negedge clk);
        mthi_i = 1'b0;
        wait_done(e, bc);
        check("hazard_hilo", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
        repeat (40) @(negedge clk);

        // MTHI/MTLO while idle.
        src_a_i = 32'h0000_ABCD;
        mthi_i  = 1'b1;
        @(posedge clk);
        #1 mthi_i = 1'b0;
        check("mthi_idle", {hi_o, lo_o}, 64'h0000_ABCD_0000_000E);
        @(negedge clk);
        src_a_i = 32'h0000_5555;
        mtlo_i  = 1'b1;
        @(posedge clk);
        #1 mtlo_i = 1'b0;
        check("mtlo_idle", {hi_o, lo_o}, 64'h0000_ABCD_0000_5555);

        // Start wins over a simultaneous MTHI.
        issue(MULTU, 32'h2, 32'h3, 1'b1);
        check("mthi_with_start", hi_o, 64'h0000_ABCD);
        wait_done(e, bc);
        check("start_wins_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_0006);

        // Asynchronous reset mid-divide discards the result.
        issue(DIV, $urandom, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midop_reset_hilo", {hi_o, lo_o}, 64'h0);
        check("midop_reset_busy", busy_o, 0);
        check("midop_reset_done", done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        run_directed("post_reset_multu", MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F);

        // Random operations; the monitor compares each result.
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            issue(2'($urandom_range(0, 3)), a, b, 1'b0);
            wait_done(e, bc);
            check("random_latency", e, 34);
        end

        repeat (40) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
